matmul_job_arbiter: RTL and testbench
=====================================

Name: matmul_job_arbiter

Overview:
- Shares one matrix_mult_top accelerator among NREQ requesters (e.g. host cores, DMA agents).
- Each requester posts a job: operand base address and mode. The arbiter buffers one pending job per requester, grants round-robin, and issues the start pulse.
- Tracks the accelerator through its compute and store phases, then returns a per-requester completion pulse.
- A watchdog aborts jobs that hang.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, job address width
TIMEOUT, 4096, max cycles from start to job end; 0 disables the watchdog
TW, 16, watchdog counter width; TIMEOUT < 2^TW

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester job-post valid
req_ready  out  NREQ  per-requester slot free
req_addr  in  NREQ*AW  per-requester base address, requester i at [i*AW +: AW]
req_mode  in  NREQ  per-requester mode bit
cmp_valid  out  NREQ  one-cycle completion pulse, one-hot
cmp_error  out  NREQ  qualifies cmp_valid; 1 = aborted by watchdog
acc_start  out  1  to start_multiply; one-cycle pulse
acc_addr  out  AW  to address_in
acc_mode  out  1  to mode
acc_done  in  1  from done_multiply; level, high during the store phase
acc_abort  out  1  one-cycle pulse; integration ORs it into the accelerator reset
busy  out  1  high in any state except IDLE
grant_id  out  $clog2(NREQ)  index of the job in flight; valid while busy

Behaviour:
- Reset (async assert, sync release): state IDLE, all slots empty, rr_ptr=0, watchdog=0. req_ready all 1. cmp_valid, cmp_error, acc_start, acc_abort, busy = 0. acc_addr=0, acc_mode=0, grant_id=0.
- Slots:
  - req_ready[i] = ~slot_valid[i], driven from a register.
  - req_valid[i] & req_ready[i] at an edge captures addr/mode into slot i; slot_valid[i]=1 from the next cycle.
  - Requests from several requesters in the same cycle are all accepted.
  - req_valid while not ready is ignored and must be held by the requester.
- FSM, all outputs registered:
  - IDLE:
    - If any slot_valid: pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
    - Load grant_id, acc_addr, acc_mode from that slot; rr_ptr <= grant+1 mod NREQ; go ISSUE.
    - acc_done is ignored in IDLE.
  - ISSUE (exactly 1 cycle): acc_start=1; watchdog cleared; go WAIT_HI.
  - WAIT_HI: wait for acc_done=1, then go WAIT_LO.
  - WAIT_LO: wait for acc_done=0, meaning the store phase is finished.
    - On that edge: cmp_valid[grant]=1 for 1 cycle, slot_valid[grant] cleared, go IDLE.
    - req_ready[grant] rises in the same cycle as cmp_valid.
  - ABORT (1 cycle):
    - Entered from WAIT_HI/WAIT_LO when the watchdog reaches TIMEOUT (TIMEOUT≠0).
    - acc_abort=1, cmp_valid[grant]=1, cmp_error[grant]=1, slot cleared; go IDLE.
- Watchdog: increments by 1 per cycle in WAIT_HI/WAIT_LO and saturates; it is compared against TIMEOUT.
- acc_addr and acc_mode stay stable from ISSUE until IDLE is re-entered. grant_id holds its last value in IDLE.
- Latency:
  - Post accepted at edge T → slot valid at T+1 → grant at edge T+1 (if IDLE) → acc_start high in cycle T+2.
  - Completion → next grant: 1 idle cycle (IDLE), then ISSUE.
- Boundary conditions:
  - Only one job is in flight.
  - The granted requester cannot post again until its cmp_valid is issued.
  - acc_done pulse of 1 cycle: WAIT_HI→WAIT_LO→done on the next low sample. This is legal.
  - acc_done low in WAIT_LO on the first cycle: completes immediately.
  - Watchdog expiry in the same cycle as acc_done falling in WAIT_LO: normal completion wins (no error, no abort).
  - rst_n asserted mid-job: all state is cleared asynchronously. No cmp_valid is emitted for the lost job; its slot is dropped.

Test Plan:
- Single job: req0 posts addr 0x1000, mode 1. Expect acc_start in cycle T+2 with acc_addr=0x1000, acc_mode=1. Drive acc_done high 20 cycles then low. Expect cmp_valid=4'b0001, cmp_error=0 one cycle after the fall, and req_ready[0] back high.
- Fairness: all 4 requesters post simultaneously, with addresses 0x0, 0x100, 0x200, 0x300. Expect grant order 0,1,2,3. Requester 0 reposts immediately after its completion; expect order then 0 again only after 1,2,3 (rr_ptr wrap).
- Back-pressure: req2 posts, then holds req_valid with new addr 0x2400 while its job is pending. Expect req_ready[2]=0 and the second post accepted only after cmp_valid[2]; the slot then contains 0x2400.
- Timeout: TIMEOUT=50, acc_done never rises. Expect acc_abort=1 and cmp_valid[g]=cmp_error[g]=1 in the same cycle, 50 cycles after WAIT_HI entry. busy returns to 0 next cycle.
- Race: TIMEOUT=50, acc_done falls on the exact expiry cycle. Expect cmp_error=0 and acc_abort=0.
- Reset mid-job: drop rst_n during WAIT_LO. Expect busy=0, acc_start=0, all req_ready=1 asynchronously, and no cmp_valid after release.

Source files
------------

// File: rtl/matmul_job_arbiter.sv
// Round-robin job arbiter that shares one matrix_mult_top among NREQ requesters.
// One buffered job per requester; tracks the compute/store phases and aborts hung jobs.
module matmul_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ-1:0]          req_mode,
    output logic [NREQ-1:0]          cmp_valid,
    output logic [NREQ-1:0]          cmp_error,
    output logic                     acc_start,
    output logic [AW-1:0]            acc_addr,
    output logic                     acc_mode,
    input  logic                     acc_done,
    output logic                     acc_abort,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam logic [TW-1:0] WD_LIMIT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ABORT
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     slot_valid_q, slot_valid_d;
    logic [AW-1:0]       slot_addr_q [NREQ];
    logic [NREQ-1:0]     slot_mode_q;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [AW-1:0]       acc_addr_q, acc_addr_d;
    logic                acc_mode_q, acc_mode_d;
    logic [TW-1:0]       wd_q, wd_d;
    logic                acc_start_q, acc_abort_q, busy_q;
    logic [NREQ-1:0]     cmp_valid_q, cmp_valid_d;
    logic [NREQ-1:0]     cmp_error_q, cmp_error_d;

    logic [NREQ-1:0]     accept;
    logic [IW-1:0]       pick;
    logic                found;
    logic                finish, finish_err;
    logic                wd_expired;
    logic [TW-1:0]       wd_inc;
    logic [NREQ-1:0]     grant_onehot;

    // A slot is free exactly when it holds no job; the slot flag is a register.
    assign req_ready = ~slot_valid_q;
    assign accept    = req_valid & ~slot_valid_q;

    assign wd_expired   = (TIMEOUT != 0) && (wd_q >= WD_LIMIT);
    assign wd_inc       = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

    // First pending slot scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && slot_valid_q[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        acc_addr_d = acc_addr_q;
        acc_mode_d = acc_mode_q;
        wd_d       = wd_q;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_ISSUE;
                    grant_d    = pick;
                    rr_ptr_d   = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    acc_addr_d = slot_addr_q[pick];
                    acc_mode_d = slot_mode_q[pick];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_HI;
                wd_d    = '0;
            end
            S_WAIT_HI: begin
                wd_d = wd_inc;
                if (wd_expired) begin
                    state_d    = S_ABORT;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (acc_done) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                wd_d = wd_inc;
                // Store phase ending on the expiry cycle still counts as a clean finish.
                if (!acc_done) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end else if (wd_expired) begin
                    state_d    = S_ABORT;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmp_valid_d  = finish ? grant_onehot : '0;
        cmp_error_d  = finish_err ? grant_onehot : '0;
        slot_valid_d = (slot_valid_q | accept) & ~cmp_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            slot_valid_q <= '0;
            slot_mode_q  <= '0;
            for (int i = 0; i < NREQ; i++) slot_addr_q[i] <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            acc_addr_q   <= '0;
            acc_mode_q   <= 1'b0;
            wd_q         <= '0;
            acc_start_q  <= 1'b0;
            acc_abort_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmp_valid_q  <= '0;
            cmp_error_q  <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    slot_addr_q[i] <= req_addr[i*AW +: AW];
                    slot_mode_q[i] <= req_mode[i];
                end
            end
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            acc_addr_q   <= acc_addr_d;
            acc_mode_q   <= acc_mode_d;
            wd_q         <= wd_d;
            acc_start_q  <= (state_d == S_ISSUE);
            acc_abort_q  <= (state_d == S_ABORT);
            busy_q       <= (state_d != S_IDLE);
            cmp_valid_q  <= cmp_valid_d;
            cmp_error_q  <= cmp_error_d;
        end
    end

    assign cmp_valid = cmp_valid_q;
    assign cmp_error = cmp_error_q;
    assign acc_start = acc_start_q;
    assign acc_abort = acc_abort_q;
    assign acc_addr  = acc_addr_q;
    assign acc_mode  = acc_mode_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter: latency, round-robin order, back-pressure,
// watchdog abort, done/expiry race and asynchronous reset mid-job.
module tb_matmul_job_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ-1:0]   cmp_valid;
    logic [NREQ-1:0]   cmp_error;
    logic              acc_start;
    logic [AW-1:0]     acc_addr;
    logic              acc_mode;
    logic              acc_done;
    logic              acc_abort;
    logic              busy;
    logic [1:0]        grant_id;

    int n_vec = 0;
    int n_err = 0;

    matmul_job_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(50), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mode(req_mode),
        .cmp_valid(cmp_valid), .cmp_error(cmp_error),
        .acc_start(acc_start), .acc_addr(acc_addr), .acc_mode(acc_mode),
        .acc_done(acc_done), .acc_abort(acc_abort),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        req_addr  = '0;
        req_mode  = '0;
        acc_done  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic post(input int i, input logic [AW-1:0] a, input logic m);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_mode[i]          = m;
    endtask

    // Waits for the grant, checks the issued job, then runs done high for hi_len cycles.
    task automatic serve_job(input int g, input logic [AW-1:0] a, input logic m,
                             input int hi_len, input int exp_wait);
        int k;
        logic [NREQ-1:0] exp_cmp;
        k = 0;
        exp_cmp = 4'b0001 << g;
        while (acc_start !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        n_vec++;
        if (acc_start !== 1'b1) begin
            n_err++;
            $display("FAIL start_wait g=%0d: acc_start=%b after %0d cycles, required 1", g, acc_start, k);
            return;
        end
        if (exp_wait >= 0) begin
            n_vec++;
            if (k !== exp_wait) begin
                n_err++;
                $display("FAIL start_latency g=%0d: %0d cycles, required %0d", g, k, exp_wait);
            end
        end
        n_vec++;
        if (grant_id !== 2'(g) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL grant g=%0d: grant_id=%0d busy=%b, required %0d/1", g, grant_id, busy, g);
        end
        n_vec++;
        if (acc_addr !== a || acc_mode !== m) begin
            n_err++;
            $display("FAIL job_fields g=%0d: addr=%h mode=%b, required %h/%b", g, acc_addr, acc_mode, a, m);
        end
        step();
        acc_done = 1'b1;
        repeat (hi_len) step();
        acc_done = 1'b0;
        step();
        n_vec++;
        if (cmp_valid !== exp_cmp || cmp_error !== 4'b0000 || acc_abort !== 1'b0) begin
            n_err++;
            $display("FAIL completion g=%0d: cmp_valid=%b cmp_error=%b abort=%b, required %b/0000/0",
                     g, cmp_valid, cmp_error, acc_abort, exp_cmp);
        end
        n_vec++;
        if (req_ready[g] !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL release g=%0d: req_ready=%b busy=%b, required ready bit 1, busy 0", g, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (req_ready !== 4'hF || busy !== 1'b0 || acc_start !== 1'b0 || acc_abort !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%b busy=%b start=%b abort=%b, required 1111/0/0/0",
                     req_ready, busy, acc_start, acc_abort);
        end
        n_vec++;
        if (cmp_valid !== 4'b0 || cmp_error !== 4'b0 || acc_addr !== 32'h0 || acc_mode !== 1'b0 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_data: cmp=%b err=%b addr=%h mode=%b gid=%0d, required all zero",
                     cmp_valid, cmp_error, acc_addr, acc_mode, grant_id);
        end
        acc_done = 1'b1;
        repeat (3) step();
        acc_done = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || acc_start !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_done: busy=%b start=%b, required 0/0", busy, acc_start);
        end
    endtask

    task automatic test_single_job();
        apply_reset();
        post(0, 32'h1000, 1'b1);
        step();
        req_valid = '0;
        n_vec++;
        if (req_ready !== 4'b1110 || acc_start !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_capture: ready=%b start=%b busy=%b, required 1110/0/0", req_ready, acc_start, busy);
        end
        serve_job(0, 32'h1000, 1'b1, 20, 1);
        step();
        n_vec++;
        if (cmp_valid !== 4'b0 || acc_addr !== 32'h1000 || grant_id !== 2'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle_hold: cmp=%b addr=%h gid=%0d busy=%b, required 0000/1000/0/0",
                     cmp_valid, acc_addr, grant_id, busy);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < NREQ; i++) post(i, 32'(i * 256), 1'(i % 2));
        step();
        req_valid = '0;
        serve_job(0, 32'h000, 1'b0, 3, 1);
        post(0, 32'h4000, 1'b0);
        step();
        req_valid = '0;
        n_vec++;
        if (req_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL repost_capture: req_ready=%b, required bit0 = 0", req_ready);
        end
        serve_job(1, 32'h100, 1'b1, 2, 0);
        serve_job(2, 32'h200, 1'b0, 5, 1);
        serve_job(3, 32'h300, 1'b1, 1, 1);
        serve_job(0, 32'h4000, 1'b0, 4, 1);
    endtask

    task automatic test_backpressure();
        apply_reset();
        post(2, 32'h2200, 1'b0);
        step();
        post(2, 32'h2400, 1'b1);
        step();
        n_vec++;
        if (req_ready[2] !== 1'b0 || acc_start !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: ready=%b start=%b, required bit2 0, start 1", req_ready, acc_start);
        end
        serve_job(2, 32'h2200, 1'b0, 6, 0);
        step();
        req_valid = '0;
        n_vec++;
        if (req_ready[2] !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: ready=%b busy=%b, required bit2 0, busy 0", req_ready, busy);
        end
        serve_job(2, 32'h2400, 1'b1, 2, 1);
    endtask

    task automatic test_timeout();
        logic early;
        apply_reset();
        post(3, 32'h3300, 1'b1);
        step();
        req_valid = '0;
        step();
        n_vec++;
        if (acc_start !== 1'b1 || grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL to_start: start=%b gid=%0d, required 1/3", acc_start, grant_id);
        end
        step();
        early = 1'b0;
        for (int c = 1; c < 50; c++) begin
            step();
            if (acc_abort !== 1'b0 || cmp_valid !== 4'b0 || busy !== 1'b1) early = 1'b1;
        end
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL to_early: abort/cmp seen before expiry (early=%b), required 0", early);
        end
        step();
        n_vec++;
        if (acc_abort !== 1'b1 || cmp_valid !== 4'b1000 || cmp_error !== 4'b1000) begin
            n_err++;
            $display("FAIL to_abort: abort=%b cmp=%b err=%b, required 1/1000/1000", acc_abort, cmp_valid, cmp_error);
        end
        n_vec++;
        if (busy !== 1'b1 || req_ready !== 4'hF) begin
            n_err++;
            $display("FAIL to_abort_state: busy=%b ready=%b, required 1/1111", busy, req_ready);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || acc_abort !== 1'b0 || cmp_valid !== 4'b0) begin
            n_err++;
            $display("FAIL to_after: busy=%b abort=%b cmp=%b, required 0/0/0000", busy, acc_abort, cmp_valid);
        end
    endtask

    task automatic test_race();
        logic early;
        apply_reset();
        post(1, 32'h1100, 1'b0);
        step();
        req_valid = '0;
        step();
        acc_done = 1'b1;
        step();
        early = 1'b0;
        for (int c = 1; c < 50; c++) begin
            step();
            if (acc_abort !== 1'b0 || cmp_valid !== 4'b0) early = 1'b1;
        end
        acc_done = 1'b0;
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL race_early: abort/cmp seen before fall (early=%b), required 0", early);
        end
        step();
        n_vec++;
        if (cmp_valid !== 4'b0010 || cmp_error !== 4'b0000 || acc_abort !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL race_done_wins: cmp=%b err=%b abort=%b busy=%b, required 0010/0000/0/0",
                     cmp_valid, cmp_error, acc_abort, busy);
        end
    endtask

    task automatic test_short_pulse();
        apply_reset();
        post(2, 32'h2C00, 1'b1);
        step();
        req_valid = '0;
        serve_job(2, 32'h2C00, 1'b1, 1, 1);
    endtask

    task automatic test_reset_mid_job();
        logic seen;
        apply_reset();
        post(0, 32'h5000, 1'b0);
        post(1, 32'h5100, 1'b1);
        step();
        req_valid = '0;
        step();
        step();
        acc_done = 1'b1;
        step();
        step();
        n_vec++;
        if (busy !== 1'b1 || req_ready !== 4'b1100) begin
            n_err++;
            $display("FAIL rst_pre: busy=%b ready=%b, required 1/1100", busy, req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || acc_start !== 1'b0 || req_ready !== 4'hF || acc_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_async: busy=%b start=%b ready=%b addr=%h, required 0/0/1111/0",
                     busy, acc_start, req_ready, acc_addr);
        end
        acc_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (cmp_valid !== 4'b0 || acc_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_completion: activity after release (seen=%b), required 0", seen);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_mode  = '0;
        acc_done  = 1'b0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_race();
        test_short_pulse();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
